nib_mem_responder: RTL and testbench

NIB_MEM_RESPONDER -- requirements
Module: nib_mem_responder

---
 rtl/rvv_pkg.sv | 22 ++
 rtl/nib_sram_1p.sv | 34 +++
 rtl/nib_mem_responder.sv | 167 ++++++++++++++++
 tb/tb_nib_mem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_pkg.sv
// Shared types and constants for the NIB memory responder.
//   NIB_PC_BANK_OFFSET : default byte distance between fetch lane 0 and lane 1
//   NIB_CNT_W          : width of the data-port latency down-counter
//   nib_ex_state_e     : data-port FSM states
//   nib_bad_addr()     : misaligned or out-of-range data access
package rvv_pkg;

  localparam logic [31:0] NIB_PC_BANK_OFFSET = 32'h0000_2000;
  localparam int unsigned NIB_CNT_W          = 4;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_WAIT = 2'd1,
    EX_RESP = 2'd2
  } nib_ex_state_e;

  // An access is bad when it is not word aligned or its word index is past the RAM.
  function automatic logic nib_bad_addr(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
  endfunction

endpackage

// File: rtl/nib_sram_1p.sv
// Word-wide memory with one synchronous write port and NRD combinational read ports.
// Contents are not touched by reset; simulation preloads them directly into mem.
//   clk   : write clock
//   we    : write enable
//   waddr : write word index
//   wdata : write data
//   raddr : one word index per read port
//   rdata : one read word per read port
module nib_sram_1p #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = 12,
  parameter int unsigned NRD   = 1
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [31:0]            wdata,
  input  logic [NRD-1:0][AW-1:0] raddr,
  output logic [NRD-1:0][31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    assign rdata[g] = mem[raddr[g]];
  end

endmodule

// File: rtl/nib_mem_responder.sv
// Data RAM + dual-lane instruction memory responder for the NIB core.
// The data port answers after EX_LAT cycles of stall (or combinationally when
// EX_LAT is 0); the fetch port returns two words one bank apart every cycle.
//   clk, rst         : clock and synchronous active-high reset
//   nib_ex_req_i     : data request          nib_ex_we_i   : 1 = write
//   nib_ex_addr_i    : data byte address     nib_ex_data_i : write data
//   nib_ex_data_o    : read data             nib_hold_req_o: stall to core
//   nib_pc_req_i     : fetch request         nib_pc_addr_i : fetch byte address
//   nib_pc_data_o    : [0] word at pc, [1] word at pc + PC_BANK_OFFSET
//   err_o            : pulse in the response cycle of a bad data access
//   wr_cnt_o         : saturating count of committed writes
module nib_mem_responder
  import rvv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 4096,
  parameter int unsigned EX_LAT         = 2,
  parameter logic [31:0] PC_BANK_OFFSET = NIB_PC_BANK_OFFSET
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nib_ex_req_i,
  input  logic             nib_ex_we_i,
  input  logic [31:0]      nib_ex_addr_i,
  input  logic [31:0]      nib_ex_data_i,
  output logic [31:0]      nib_ex_data_o,
  output logic             nib_hold_req_o,
  input  logic             nib_pc_req_i,
  input  logic [31:0]      nib_pc_addr_i,
  output logic [1:0][31:0] nib_pc_data_o,
  output logic             err_o,
  output logic [15:0]      wr_cnt_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  nib_ex_state_e        state_q, state_d;
  logic [NIB_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          lat_addr_q, lat_data_q;
  logic                 lat_we_q;
  logic [31:0]          ex_data_q;
  logic [15:0]          wr_cnt_q;
  logic [1:0][31:0]     lane_q;

  logic                 accept_c, resp_c, bad_c, commit_c, acc_we;
  logic [31:0]          acc_addr, acc_data, rd_val;
  logic [0:0][AW-1:0]   dram_raddr;
  logic [0:0][31:0]     dram_rdata;
  logic [1:0][AW-1:0]   imem_raddr;
  logic [1:0][31:0]     imem_rdata;
  logic [31:0]          pc_addr_b;
  logic                 unused_pc_b;

  // Data-port FSM: next state, stall and response strobes.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    accept_c       = 1'b0;
    resp_c         = 1'b0;
    nib_hold_req_o = 1'b0;
    case (state_q)
      EX_IDLE: begin
        if (nib_ex_req_i) begin
          if (EX_LAT == 0) begin
            resp_c = 1'b1;
          end else begin
            accept_c       = 1'b1;
            nib_hold_req_o = 1'b1;
            cnt_d          = NIB_CNT_W'(EX_LAT - 1);
            state_d        = (EX_LAT == 1) ? EX_RESP : EX_WAIT;
          end
        end
      end
      EX_WAIT: begin
        // cnt holds the stall cycles still owed including this one, so the
        // accept cycle plus the WAIT cycles add up to exactly EX_LAT.
        nib_hold_req_o = 1'b1;
        if (cnt_q <= NIB_CNT_W'(1)) begin
          state_d = EX_RESP;
        end else begin
          cnt_d = cnt_q - NIB_CNT_W'(1);
        end
      end
      EX_RESP: begin
        resp_c  = 1'b1;
        state_d = EX_IDLE;
      end
      default: state_d = EX_IDLE;
    endcase
    // Reset suppresses the stall and any in-flight commit or response.
    if (rst) begin
      accept_c       = 1'b0;
      resp_c         = 1'b0;
      nib_hold_req_o = 1'b0;
    end
  end

  // With zero latency the live inputs are served; otherwise the latched request.
  assign acc_addr = (EX_LAT == 0) ? nib_ex_addr_i : lat_addr_q;
  assign acc_data = (EX_LAT == 0) ? nib_ex_data_i : lat_data_q;
  assign acc_we   = (EX_LAT == 0) ? nib_ex_we_i   : lat_we_q;

  assign bad_c         = nib_bad_addr(acc_addr, DEPTH_WORDS);
  assign rd_val        = bad_c ? 32'h0 : dram_rdata[0];
  assign commit_c      = resp_c && acc_we && !bad_c;
  assign err_o         = resp_c && bad_c;
  assign nib_ex_data_o = (resp_c && !acc_we) ? rd_val : ex_data_q;
  assign wr_cnt_o      = wr_cnt_q;
  assign dram_raddr[0] = acc_addr[AW+1:2];

  // Lane 1 wraps through the top of the instruction memory (DEPTH is a power of two).
  assign pc_addr_b     = nib_pc_addr_i + PC_BANK_OFFSET;
  assign imem_raddr[0] = nib_pc_addr_i[AW+1:2];
  assign imem_raddr[1] = pc_addr_b[AW+1:2];
  assign nib_pc_data_o = nib_pc_req_i ? imem_rdata : lane_q;
  assign unused_pc_b   = ^{pc_addr_b[31:AW+2], pc_addr_b[1:0]};

  // State, request latch, read-data hold, write counter and fetch lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EX_IDLE;
      cnt_q      <= '0;
      lat_addr_q <= '0;
      lat_data_q <= '0;
      lat_we_q   <= 1'b0;
      ex_data_q  <= '0;
      wr_cnt_q   <= '0;
      lane_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_c) begin
        lat_addr_q <= nib_ex_addr_i;
        lat_data_q <= nib_ex_data_i;
        lat_we_q   <= nib_ex_we_i;
      end
      if (resp_c && !acc_we) begin
        ex_data_q <= rd_val;
      end
      if (commit_c && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
      if (nib_pc_req_i) begin
        lane_q <= imem_rdata;
      end
    end
  end

  nib_sram_1p #(.DEPTH(DEPTH_WORDS), .AW(AW), .NRD(1)) u_dram (
    .clk   (clk),
    .we    (commit_c),
    .waddr (acc_addr[AW+1:2]),
    .wdata (acc_data),
    .raddr (dram_raddr),
    .rdata (dram_rdata)
  );

  // Instruction memory has no write path from the ports.
  nib_sram_1p #(.DEPTH(DEPTH_WORDS), .AW(AW), .NRD(2)) u_imem (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata (32'h0),
    .raddr (imem_raddr),
    .rdata (imem_rdata)
  );

endmodule

// File: tb/tb_nib_mem_responder.sv
// Bench for nib_mem_responder: three instances at EX_LAT 0, 2 and 3 are driven
// with directed and $urandom traffic and compared to a word-level memory model.
module tb_nib_mem_responder;

  localparam int unsigned DEPTH = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_req   [3];
  logic              ex_we    [3];
  logic [31:0]       ex_addr  [3];
  logic [31:0]       ex_wdata [3];
  logic [31:0]       ex_rdata [3];
  logic              hold     [3];
  logic              err      [3];
  logic [15:0]       wr_cnt   [3];
  logic              pc_req   [3];
  logic [31:0]       pc_addr  [3];
  logic [1:0][31:0]  lanes    [3];

  int checks   = 0;
  int failures = 0;

  logic [31:0] mdl  [int unsigned];
  logic [31:0] imod [int unsigned];
  int          exp_wr   [3];
  logic [31:0] exp_last [3];

  always #5 clk = ~clk;

  nib_mem_responder #(.EX_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .nib_ex_req_i(ex_req[0]), .nib_ex_we_i(ex_we[0]),
    .nib_ex_addr_i(ex_addr[0]), .nib_ex_data_i(ex_wdata[0]), .nib_ex_data_o(ex_rdata[0]),
    .nib_hold_req_o(hold[0]), .nib_pc_req_i(pc_req[0]), .nib_pc_addr_i(pc_addr[0]),
    .nib_pc_data_o(lanes[0]), .err_o(err[0]), .wr_cnt_o(wr_cnt[0]));

  nib_mem_responder #(.EX_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst), .nib_ex_req_i(ex_req[1]), .nib_ex_we_i(ex_we[1]),
    .nib_ex_addr_i(ex_addr[1]), .nib_ex_data_i(ex_wdata[1]), .nib_ex_data_o(ex_rdata[1]),
    .nib_hold_req_o(hold[1]), .nib_pc_req_i(pc_req[1]), .nib_pc_addr_i(pc_addr[1]),
    .nib_pc_data_o(lanes[1]), .err_o(err[1]), .wr_cnt_o(wr_cnt[1]));

  nib_mem_responder #(.EX_LAT(3)) u_dut2 (
    .clk(clk), .rst(rst), .nib_ex_req_i(ex_req[2]), .nib_ex_we_i(ex_we[2]),
    .nib_ex_addr_i(ex_addr[2]), .nib_ex_data_i(ex_wdata[2]), .nib_ex_data_o(ex_rdata[2]),
    .nib_hold_req_o(hold[2]), .nib_pc_req_i(pc_req[2]), .nib_pc_addr_i(pc_addr[2]),
    .nib_pc_data_o(lanes[2]), .err_o(err[2]), .wr_cnt_o(wr_cnt[2]));

  function automatic int lat_of(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int unsigned mkey(input int k, input logic [31:0] addr);
    return 32'(k) * 32'd65536 + (addr >> 2);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One data access on instance k; checks stall, error and read data every cycle.
  task automatic do_access(input int k, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input bit post, input string tag);
    int          lat;
    bit          bad;
    logic [31:0] exp_rd;
    lat    = lat_of(k);
    bad    = (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
    exp_rd = 32'h0;
    if (!bad && mdl.exists(mkey(k, addr))) exp_rd = mdl[mkey(k, addr)];
    ex_req[k] = 1'b1; ex_we[k] = we; ex_addr[k] = addr; ex_wdata[k] = data;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      chk($sformatf("%s.k%0d.hold%0d", tag, k, c), 64'(hold[k]), 64'(c < lat));
      if (c == lat) begin
        chk($sformatf("%s.k%0d.err", tag, k), 64'(err[k]), 64'(bad));
        chk($sformatf("%s.k%0d.wrcnt_pre", tag, k), 64'(wr_cnt[k]), 64'(exp_wr[k]));
        if (!we) chk($sformatf("%s.k%0d.rdata", tag, k), 64'(ex_rdata[k]), 64'(exp_rd));
      end else begin
        chk($sformatf("%s.k%0d.err_early", tag, k), 64'(err[k]), 64'(0));
      end
      @(posedge clk); #1;
      // Scramble the request inputs after the accept edge; they must be ignored.
      if (c == 0) begin
        ex_req[k] = 1'($urandom); ex_we[k] = 1'($urandom);
        ex_addr[k] = $urandom;    ex_wdata[k] = $urandom;
      end
    end
    ex_req[k] = 1'b0;
    if (we && !bad) begin
      mdl[mkey(k, addr)] = data;
      if (exp_wr[k] != 65535) exp_wr[k]++;
    end
    if (!we) exp_last[k] = exp_rd;
    if (post) begin
      @(negedge clk);
      chk($sformatf("%s.k%0d.wrcnt", tag, k), 64'(wr_cnt[k]), 64'(exp_wr[k]));
      chk($sformatf("%s.k%0d.dhold", tag, k), 64'(ex_rdata[k]), 64'(exp_last[k]));
      chk($sformatf("%s.k%0d.idle_hold", tag, k), 64'(hold[k]), 64'(0));
      chk($sformatf("%s.k%0d.idle_err", tag, k), 64'(err[k]), 64'(0));
      @(posedge clk); #1;
    end
  endtask

  task automatic imem_load(input int unsigned idx, input logic [31:0] val);
    imod[idx % DEPTH] = val;
    u_dut1.u_imem.mem[idx % DEPTH] <= val;
  endtask

  // Fetch on the EX_LAT=2 instance, then drop the request and expect the lanes to hold.
  task automatic do_fetch(input logic [31:0] a, input string tag);
    logic [31:0] e0, e1;
    e0 = imod[(a >> 2) % DEPTH];
    e1 = imod[((a + 32'h2000) >> 2) % DEPTH];
    pc_req[1] = 1'b1; pc_addr[1] = a;
    @(negedge clk);
    chk({tag, ".live"}, 64'(lanes[1]), {e1, e0});
    chk({tag, ".err"}, 64'(err[1]), 64'(0));
    @(posedge clk); #1;
    pc_req[1] = 1'b0; pc_addr[1] = $urandom;
    @(negedge clk);
    chk({tag, ".held"}, 64'(lanes[1]), {e1, e0});
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pool [3][6];
    logic [31:0] addrs [10];
    logic [31:0] a, d, e0, e1;
    int unsigned idx;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ex_req[k] = 1'b0; ex_we[k] = 1'b0; ex_addr[k] = '0; ex_wdata[k] = '0;
      pc_req[k] = 1'b0; pc_addr[k] = '0; exp_wr[k] = 0; exp_last[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst.k%0d.hold", k), 64'(hold[k]), 64'(0));
      chk($sformatf("rst.k%0d.err", k), 64'(err[k]), 64'(0));
      chk($sformatf("rst.k%0d.wrcnt", k), 64'(wr_cnt[k]), 64'(0));
      chk($sformatf("rst.k%0d.rdata", k), 64'(ex_rdata[k]), 64'(0));
      chk($sformatf("rst.k%0d.lanes", k), 64'(lanes[k]), 64'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Instruction memory image: the two directed words plus random pairs.
    imem_load(0, 32'h0000_0013);
    imem_load(2048, 32'h0000_0001);
    for (int i = 0; i < 6; i++) begin
      idx = $urandom_range(1, 2047);
      imem_load(idx, $urandom);
      imem_load(idx + 2048, $urandom);
    end
    @(posedge clk); #1;

    // Write then read back at EX_LAT=2 and EX_LAT=0.
    do_access(1, 1'b1, 32'h10, 32'hCAFE_0001, 1'b1, "wr10");
    do_access(1, 1'b0, 32'h10, 32'h0, 1'b1, "rd10");
    do_access(0, 1'b1, 32'h10, $urandom, 1'b1, "wr10");
    do_access(0, 1'b0, 32'h10, 32'h0, 1'b1, "rd10");

    // Out-of-range read and misaligned write on every latency.
    for (int k = 0; k < 3; k++) begin
      do_access(k, 1'b0, 32'h4000, 32'h0, 1'b1, "rd_oor");
      do_access(k, 1'b1, 32'h13, $urandom, 1'b1, "wr_mis");
    end

    // Fetch port: directed lanes, random fetches, and a fetch alongside a data access.
    do_fetch(32'h0, "fetch0");
    for (int i = 0; i < 6; i++) begin
      a = {18'h0, 12'($urandom_range(0, 4095)), 2'($urandom)};
      if (imod.exists((a >> 2) % DEPTH) && imod.exists(((a + 32'h2000) >> 2) % DEPTH))
        do_fetch(a, "fetch_rnd");
      else
        do_fetch(32'h0, "fetch_rep");
    end
    a  = 32'h0000_0003;
    e0 = imod[0];
    e1 = imod[2048];
    pc_req[1] = 1'b1; pc_addr[1] = a;
    do_access(1, 1'b0, 32'h10, 32'h0, 1'b0, "rd_fetch");
    @(negedge clk);
    chk("concurrent.lanes", 64'(lanes[1]), {e1, e0});
    @(posedge clk); #1;
    pc_req[1] = 1'b0;

    // Back-to-back writes and reads at EX_LAT=3; each access must take exactly 4 cycles.
    for (int i = 0; i < 10; i++) begin
      addrs[i] = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
      do_access(2, 1'b1, addrs[i], $urandom, (i == 9), "b2b_wr");
    end
    for (int i = 0; i < 10; i++) begin
      do_access(2, 1'b0, addrs[i], 32'h0, (i == 9), "b2b_rd");
    end

    // Random mix of good writes, reads of written words and bad accesses.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) pool[k][i] = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
      for (int i = 0; i < 25; i++) begin
        int r;
        r = $urandom_range(0, 9);
        a = pool[k][$urandom_range(0, 5)];
        d = $urandom;
        if (r < 4 || !mdl.exists(mkey(k, a)))
          do_access(k, 1'b1, a, d, 1'($urandom), "mix_wr");
        else if (r < 8)
          do_access(k, 1'b0, a, 32'h0, 1'($urandom), "mix_rd");
        else if (r == 8)
          do_access(k, 1'($urandom), a | 32'(2'($urandom_range(1, 3))), d, 1'b1, "mix_mis");
        else
          do_access(k, 1'($urandom), 32'h4000 + (32'($urandom_range(0, 255)) << 2), d, 1'b1, "mix_oor");
      end
    end

    // Reset in the WAIT cycle of a write drops that write.
    do_access(1, 1'b1, 32'h20, 32'h1234_5678, 1'b1, "rst_pre");
    ex_req[1] = 1'b1; ex_we[1] = 1'b1; ex_addr[1] = 32'h20; ex_wdata[1] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    ex_req[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait.hold_in_rst", 64'(hold[1]), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_wr[k] = 0;
      exp_last[k] = '0;
    end
    @(negedge clk);
    chk("rst_wait.hold", 64'(hold[1]), 64'(0));
    chk("rst_wait.wrcnt", 64'(wr_cnt[1]), 64'(0));
    chk("rst_wait.rdata", 64'(ex_rdata[1]), 64'(0));
    chk("rst_wait.lanes", 64'(lanes[1]), 64'(0));
    @(posedge clk); #1;
    do_access(1, 1'b0, 32'h20, 32'h0, 1'b1, "rst_post_rd");
    do_access(1, 1'b0, 32'h10, 32'h0, 1'b1, "rst_post_rd10");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
